// File: rtl/flappy_game_fsm_pkg.sv
// Shared constants and helpers for the Flappy Bird datapath: game state
// encoding, screen geometry and BCD score arithmetic.
package flappy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_FALL = 2'd2,
        ST_OVER = 2'd3
    } state_t;

    localparam int H_POS       = 320;
    localparam int BIRD_XWIDTH = 34;
    localparam int LAND_HEIGHT = 100;
    localparam int HOLDOFF_MS  = 500;

    localparam logic [9:0]  SCORE_X     = 10'(H_POS - BIRD_XWIDTH);
    localparam logic [12:0] LAND_Y      = 13'(LAND_HEIGHT);
    localparam logic [9:0]  HOLDOFF_MAX = 10'(HOLDOFF_MS);

    // Three-digit BCD ripple increment; 999 holds instead of wrapping.
    function automatic logic [11:0] bcd_inc_sat(input logic [11:0] value);
        logic [11:0] next;
        logic        carry;
        next  = value;
        carry = 1'b1;
        if (value != 12'h999) begin
            for (int d = 0; d < 3; d++) begin
                if (carry) begin
                    if (next[d*4 +: 4] == 4'd9) begin
                        next[d*4 +: 4] = 4'd0;
                    end else begin
                        next[d*4 +: 4] = next[d*4 +: 4] + 4'd1;
                        carry          = 1'b0;
                    end
                end
            end
        end
        return next;
    endfunction

endpackage

// File: rtl/flappy_game_fsm_if.sv
// Game-sequencer signal bundle: the bird/pipe side drives the inputs
// (master), the sequencer drives state and scores (slave).
interface flappy_game_fsm_if;

    logic        button;
    logic        isDead;
    logic [12:0] V_pos;
    logic [9:0]  pip1_X;
    logic [1:0]  state;
    logic        scroll_en;
    logic [11:0] score;
    logic [11:0] best;
    logic        new_best;

    modport master (
        output button, isDead, V_pos, pip1_X,
        input  state, scroll_en, score, best, new_best
    );

    modport slave (
        input  button, isDead, V_pos, pip1_X,
        output state, scroll_en, score, best, new_best
    );

endinterface

// File: rtl/flappy_game_fsm_bcd.sv
// Three-digit BCD up-counter with synchronous clear, saturating at 999.
module bcd_counter3
    import flappy_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clear,
    input  logic        i_inc,
    output logic [11:0] o_value
);

    logic [11:0] r_value;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= '0;
        end else if (i_clear) begin
            r_value <= '0;
        end else if (i_inc) begin
            r_value <= bcd_inc_sat(r_value);
        end
    end

    assign o_value = r_value;

endmodule

// File: rtl/flappy_game_fsm.sv
// Game sequencer: idle -> play -> fall -> over -> idle, with BCD score,
// best score and a restart holdoff after game over.
module flappy_game_fsm
    import flappy_pkg::*;
(
    input  logic              clk_ms,
    input  logic              rst_n,
    flappy_game_fsm_if.slave  bus
);

    state_t      r_state;
    logic [11:0] r_best;
    logic        r_new_best;
    logic [9:0]  r_holdoff;
    logic [1:0]  r_btn_q;
    logic [9:0]  r_pip1_X_q;

    logic        w_press;
    logic        w_cross;
    logic        w_score_clr;
    logic        w_score_inc;
    logic [11:0] w_score;

    // Bit 0 holds the newest button sample, bit 1 the one before it.
    assign w_press     = (r_btn_q == 2'b01);
    // Only a falling pip1_X can cross the score line, so a recycle jump never scores.
    assign w_cross     = (r_pip1_X_q >= SCORE_X) && (bus.pip1_X < SCORE_X);
    assign w_score_clr = (r_state == ST_IDLE) && w_press;
    assign w_score_inc = (r_state == ST_PLAY) && !bus.isDead && w_cross;

    bcd_counter3 u_score (
        .clk     (clk_ms),
        .rst_n   (rst_n),
        .i_clear (w_score_clr),
        .i_inc   (w_score_inc),
        .o_value (w_score)
    );

    always_ff @(posedge clk_ms or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_best     <= '0;
            r_new_best <= 1'b0;
            r_holdoff  <= '0;
            r_btn_q    <= '0;
            r_pip1_X_q <= '0;
        end else begin
            r_btn_q    <= {r_btn_q[0], bus.button};
            r_pip1_X_q <= bus.pip1_X;
            case (r_state)
                ST_IDLE: begin
                    if (w_press) begin
                        r_state    <= ST_PLAY;
                        r_new_best <= 1'b0;
                    end
                end
                ST_PLAY: begin
                    if (bus.isDead) begin
                        r_state <= ST_FALL;
                    end
                end
                ST_FALL: begin
                    if (bus.V_pos < LAND_Y) begin
                        r_state   <= ST_OVER;
                        r_holdoff <= '0;
                        // Plain unsigned compare orders BCD values correctly.
                        if (w_score > r_best) begin
                            r_best     <= w_score;
                            r_new_best <= 1'b1;
                        end
                    end
                end
                ST_OVER: begin
                    if (r_holdoff != HOLDOFF_MAX) begin
                        r_holdoff <= r_holdoff + 10'd1;
                    end
                    if (w_press && (r_holdoff == HOLDOFF_MAX)) begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.state     = r_state;
    assign bus.scroll_en = (r_state == ST_PLAY);
    assign bus.score     = w_score;
    assign bus.best      = r_best;
    assign bus.new_best  = r_new_best;

endmodule

// File: tb/tb_flappy_game_fsm.sv
// Bench for flappy_game_fsm: directed game scenarios plus randomized play,
// compared every cycle against an integer-level model of the game rules.
module tb_flappy_game_fsm;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    flappy_game_fsm_if bus ();

    flappy_game_fsm dut (
        .clk_ms (clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: plain integers for state, decimal score and counters.
    int m_state   = 0;
    int m_score   = 0;
    int m_best    = 0;
    int m_over    = 0;
    int m_px_prev = 0;
    bit m_nb      = 1'b0;
    bit m_b_old   = 1'b0;
    bit m_b_new   = 1'b0;
    bit m_press;
    bit m_cross;

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state   = 0;
            m_score   = 0;
            m_best    = 0;
            m_over    = 0;
            m_px_prev = 0;
            m_nb      = 1'b0;
            m_b_old   = 1'b0;
            m_b_new   = 1'b0;
        end else begin
            m_press = m_b_new && !m_b_old;
            m_cross = (m_px_prev >= 286) && (int'(bus.pip1_X) < 286);
            case (m_state)
                0: if (m_press) begin
                    m_state = 1;
                    m_score = 0;
                    m_nb    = 1'b0;
                end
                1: if (bus.isDead) m_state = 2;
                   else if (m_cross && m_score < 999) m_score = m_score + 1;
                2: if (int'(bus.V_pos) < 100) begin
                    m_state = 3;
                    m_over  = 0;
                    if (m_score > m_best) begin
                        m_best = m_score;
                        m_nb   = 1'b1;
                    end
                end
                default: begin
                    if (m_press && m_over >= 500) m_state = 0;
                    if (m_over < 500) m_over = m_over + 1;
                end
            endcase
            m_b_old   = m_b_new;
            m_b_new   = bus.button;
            m_px_prev = int'(bus.pip1_X);
        end
    end

    always @(negedge clk) begin
        chk("state",     32'(bus.state),     32'(m_state));
        chk("scroll_en", 32'(bus.scroll_en), 32'(m_state == 1));
        chk("score",     32'(bus.score),     32'(to_bcd(m_score)));
        chk("best",      32'(bus.best),      32'(to_bcd(m_best)));
        chk("new_best",  32'(bus.new_best),  32'(m_nb));
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic cross_once();
        bus.pip1_X = 10'd286;
        step(1);
        bus.pip1_X = 10'd285;
        step(1);
    endtask

    task automatic press_btn();
        bus.button = 1'b1;
        step(2);
        bus.button = 1'b0;
    endtask

    int px;

    initial begin
        bus.button = 1'b0;
        bus.isDead = 1'b0;
        bus.V_pos  = 13'd500;
        bus.pip1_X = 10'd600;
        step(2);
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_score", 32'(bus.score), 32'h000);
        chk("rst_best",  32'(bus.best),  32'h000);
        chk("rst_nb",    32'(bus.new_best), 32'd0);
        chk("rst_scroll", 32'(bus.scroll_en), 32'd0);
        rst_n = 1'b1;

        // Start: two-tick latency from button rise to PLAY; button stays held.
        step(9);
        bus.button = 1'b1;
        step(1);
        chk("start_lat1", 32'(bus.state), 32'd0);
        step(1);
        chk("start_state", 32'(bus.state), 32'd1);
        chk("start_scroll", 32'(bus.scroll_en), 32'd1);
        chk("start_score", 32'(bus.score), 32'h000);

        // Score line crossings and recycle jump.
        bus.pip1_X = 10'd290; step(1);
        bus.pip1_X = 10'd287; step(1);
        bus.pip1_X = 10'd286; step(1);
        chk("at_line", 32'(bus.score), 32'h000);
        bus.pip1_X = 10'd285; step(1);
        chk("cross1", 32'(bus.score), 32'h001);
        bus.pip1_X = 10'd639; step(1);
        chk("recycle", 32'(bus.score), 32'h001);
        bus.pip1_X = 10'd400; step(1);
        bus.pip1_X = 10'd300; step(1);
        bus.pip1_X = 10'd286; step(1);
        bus.pip1_X = 10'd285; step(1);
        chk("cross2", 32'(bus.score), 32'h002);
        bus.button = 1'b0;
        chk("held_btn", 32'(bus.state), 32'd1);

        // BCD carries.
        repeat (7) cross_once();
        chk("bcd_009", 32'(bus.score), 32'h009);
        cross_once();
        chk("bcd_010", 32'(bus.score), 32'h010);
        repeat (89) cross_once();
        chk("bcd_099", 32'(bus.score), 32'h099);
        cross_once();
        chk("bcd_100", 32'(bus.score), 32'h100);

        // Death on a crossing tick wins; FALL ignores presses; landing records best.
        bus.pip1_X = 10'd286; step(1);
        bus.pip1_X = 10'd285;
        bus.isDead = 1'b1;
        step(1);
        bus.isDead = 1'b0;
        chk("dead_state", 32'(bus.state), 32'd2);
        chk("dead_score", 32'(bus.score), 32'h100);
        press_btn();
        step(1);
        chk("fall_press", 32'(bus.state), 32'd2);
        bus.V_pos = 13'd99;
        step(1);
        bus.V_pos = 13'd500;
        chk("over_state", 32'(bus.state), 32'd3);
        chk("over_best", 32'(bus.best), 32'h100);
        chk("over_nb", 32'(bus.new_best), 32'd1);

        // Early restart is refused, late restart accepted, best retained.
        step(98);
        press_btn();
        chk("holdoff_early", 32'(bus.state), 32'd3);
        step(500);
        press_btn();
        chk("restart_idle", 32'(bus.state), 32'd0);
        step(1);
        press_btn();
        chk("replay_state", 32'(bus.state), 32'd1);
        chk("replay_score", 32'(bus.score), 32'h000);
        chk("replay_best", 32'(bus.best), 32'h100);
        chk("replay_nb", 32'(bus.new_best), 32'd0);
        step(1);

        // Randomized play across several games.
        px = 600;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0) bus.button = ~bus.button;
            bus.isDead = ($urandom_range(0, 60) == 0);
            bus.V_pos  = ($urandom_range(0, 9) == 0) ? 13'($urandom_range(0, 99))
                                                     : 13'($urandom_range(100, 8191));
            px = px - int'($urandom_range(0, 4));
            if (px < 200) px = 639;
            bus.pip1_X = 10'(px);
            step(1);
        end
        bus.button = 1'b0;
        bus.isDead = 1'b0;
        bus.V_pos  = 13'd500;

        rst_n = 1'b0;
        #1;
        chk("mid_rst_state", 32'(bus.state), 32'd0);
        chk("mid_rst_best", 32'(bus.best), 32'h000);
        step(1);
        rst_n = 1'b1;
        step(2);

        // Build best = 005, reach FALL in the next game, then reset.
        press_btn();
        chk("g2_state", 32'(bus.state), 32'd1);
        step(1);
        repeat (5) cross_once();
        bus.isDead = 1'b1; step(1); bus.isDead = 1'b0;
        bus.V_pos = 13'd50; step(1); bus.V_pos = 13'd500;
        chk("g2_best", 32'(bus.best), 32'h005);
        step(510);
        press_btn();
        step(1);
        press_btn();
        step(1);
        bus.isDead = 1'b1; step(1); bus.isDead = 1'b0;
        chk("g3_fall", 32'(bus.state), 32'd2);
        chk("g3_best", 32'(bus.best), 32'h005);
        rst_n = 1'b0;
        #1;
        chk("fall_rst_state", 32'(bus.state), 32'd0);
        chk("fall_rst_best", 32'(bus.best), 32'h000);
        chk("fall_rst_scroll", 32'(bus.scroll_en), 32'd0);
        step(1);
        rst_n = 1'b1;
        step(2);

        // Saturation at 999.
        press_btn();
        step(1);
        repeat (998) cross_once();
        chk("sat_998", 32'(bus.score), 32'h998);
        cross_once();
        chk("sat_999", 32'(bus.score), 32'h999);
        repeat (2) cross_once();
        chk("sat_hold", 32'(bus.score), 32'h999);
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/flappy_game_fsm.md
# flappy_game_fsm

Top-level game sequencer for the Flappy Bird datapath. Owns the 2-bit game `state` consumed by the bird controller and pipe generator, and sequences idle → play → fall → game-over → idle. Keeps the 3-digit BCD current score and best score, and gates pipe scrolling. Runs on the 1 ms game tick alongside the bird and pipe blocks.

## Interface
- `H_POS`, 320: bird left-edge X reference (pixels).
- `BIRD_XWIDTH`, 34: bird sprite width; score line is `SCORE_X = H_POS - BIRD_XWIDTH` (286).
- `LAND_HEIGHT`, 100: ground Y; the bird is grounded when `V_pos < LAND_HEIGHT`.
- `HOLDOFF_MS`, 500: minimum ticks in OVER before a restart press is accepted.
- `clk_ms`  in  1  1 ms game clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `button`  in  1  raw flap/start button, already synchronous to `clk_ms`.
- `isDead`  in  1  collision flag from the bird controller.
- `V_pos`  in  13  bird vertical position.
- `pip1_X`  in  10  X of the nearest pipe's right edge; decreases by scrolling and jumps upward on recycle.
- `state`  out  2  0 IDLE, 1 PLAY, 2 FALL, 3 OVER.
- `scroll_en`  out  1  pipe scroll enable.
- `score`  out  12  current score, 3 BCD digits.
- `best`  out  12  best score, 3 BCD digits.
- `new_best`  out  1  high in OVER when the last run set a new best.

## Operation
- Button edge: 2-flop history `btn_q`; `press = btn_q == 2'b01`. This is a rising edge, one tick wide.
- IDLE:
  - On `press` → PLAY.
  - Clear `score` and `new_best` on the same edge.
- PLAY:
  - If `isDead` → FALL.
  - Otherwise, on score crossing (`pip1_X_q >= SCORE_X && pip1_X < SCORE_X`), increment `score`.
  - `pip1_X_q` is the previous-tick `pip1_X` and is registered in every state.
  - If `isDead` and a crossing occur on the same tick, `isDead` wins and there is no increment.
- FALL:
  - `press` is ignored.
  - When `V_pos < LAND_HEIGHT` → OVER.
  - On the same edge, if `score > best`: `best <= score` and `new_best <= 1`.
- OVER:
  - `holdoff` counter (10 bits) counts up from 0 and saturates at `HOLDOFF_MS`.
  - `press` is accepted only when `holdoff == HOLDOFF_MS` → IDLE.
  - `holdoff` clears on entry to OVER.
- State 3 → IDLE only via a press. Unused encodings do not exist (2 bits, all used).
- Score arithmetic: BCD ripple. Digit 9 + 1 → 0 with carry. Saturates at 999; no wrap.
- Comparison `score > best` is a 12-bit unsigned compare, valid because the values are BCD.
- `scroll_en = (state == PLAY)`, combinational from the state register.
- Pipe recycle (`pip1_X` jumping upward) never produces a crossing, because the crossing test requires a falling value.

## Timing
- Reset (async, `rst_n` low) forces:
  - `state = 0`, `score = 0`, `best = 0`, `new_best = 0`;
  - `holdoff = 0`, `btn_q = 0`, `pip1_X_q = 0`.
- Reset mid-game also clears `best`.
- All outputs are registered except `scroll_en`.
- `press` is seen 1 tick after `button` rises, and the state changes on that tick's edge. So the button-rise-to-state latency is 2 ticks; the bird controller sees the same edge.
- `isDead` → FALL: 1 tick.
- Ground → OVER: 1 tick.
- Score update: 1 tick after the crossing tick.
- `best` / `new_best` update on the FALL→OVER edge.
- OVER holdoff: restart is accepted no earlier than `HOLDOFF_MS` ticks after OVER entry.
- A held button produces no repeated presses.

## Structure
- Package `flappy_pkg`:
  - state constants `ST_IDLE/ST_PLAY/ST_FALL/ST_OVER`;
  - shared geometry constants (`H_POS`, `LAND_HEIGHT`, `BIRD_XWIDTH`), also used by the bird and pipe blocks.
- Sub-module `bcd_counter3`:
  - inputs: clk, async rst_n, synchronous clear, increment;
  - output: 12-bit BCD value;
  - saturates at 999.
  - Instantiated once for `score`. `best` is a plain register.

## Test plan
- Reset then `button` rise at tick 10 → `state` = 1 at tick 12, `scroll_en` = 1, `score` = 0.
- In PLAY, drive `pip1_X` 290, 287, 286, 285 → `score` = 001 one tick after 285. Then jump to 639 and descend past 286 again → `score` = 002. A jump 285→639 alone gives no increment.
- In PLAY, assert `isDead` on the same tick as a crossing → `state` = 2 and `score` unchanged. Drop `V_pos` to 99 → `state` = 3 next tick, with `best` = `score` and `new_best` = 1.
- In OVER, press at holdoff 100 → stays 3. Press at tick ≥ 500 → `state` = 0. Next press → PLAY with `score` cleared and `best` retained.
- Preload `score` to 998 and force 3 crossings → `score` goes 999 then stays 999. Check the BCD carry at 009→010 and 099→100.
- Assert `rst_n` low in FALL with `best` = 005 → immediately `state` = 0, `best` = 0, `scroll_en` = 0.
